command_sequencer: RTL and testbench

//   Initiator side of the datapath command interface: stores a short program of
//   {command, operand} words and replays it, one word per clock, onto the 4-bit

---
 rtl/command_sequencer.sv | 150 +++++++++++++++
 tb/tb_command_sequencer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/command_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : command_sequencer
// Brief    : Stores a short {command, operand} program and replays it one word
//            per clock onto the datapath command/operand buses.
//            Optional single-step mode enabled by defining SINGLE_STEP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module command_sequencer #(
    parameter int         DEPTH    = 16,
    parameter int         AW       = $clog2(DEPTH),
    parameter logic [3:0] NOP_CMD  = 4'hE,
    parameter logic [3:0] HALT_CMD = 4'hF
) (
    input  logic          clock,
    input  logic          CLR,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [11:0]   prog_data,
    input  logic          start,
`ifdef SINGLE_STEP_EN
    input  logic          step,
`endif
    output logic [3:0]    cmd_out,
    output logic [7:0]    data_out,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    logic [11:0]   mem [DEPTH];

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [3:0]    cmd_q, cmd_d;
    logic [7:0]    data_q, data_d;
    logic          last_q, last_d;
    logic          mem_we;
    logic          fetch_en;

    logic [3:0]    w0_cmd;
    logic [7:0]    w0_opd;
    logic [3:0]    wp_cmd;
    logic [7:0]    wp_opd;

    assign w0_cmd = mem[0][11:8];
    assign w0_opd = mem[0][7:0];
    assign wp_cmd = mem[pc_q][11:8];
    assign wp_opd = mem[pc_q][7:0];

`ifdef SINGLE_STEP_EN
    assign fetch_en = step;
`else
    assign fetch_en = 1'b1;
`endif

    // Program storage has no reset: contents survive CLR.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[prog_addr] <= prog_data;
        end
    end

    always_ff @(posedge clock or posedge CLR) begin
        if (CLR) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            cmd_q   <= NOP_CMD;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cmd_q   <= cmd_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cmd_d   = NOP_CMD;
        data_d  = '0;
        last_d  = last_q;
        mem_we  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    last_d = 1'b0;
                    if (w0_cmd == HALT_CMD) begin
                        pc_d    = '0;
                        state_d = S_DONE;
                    end else begin
                        cmd_d   = w0_cmd;
                        data_d  = w0_opd;
                        pc_d    = AW'(1);
                        state_d = S_RUN;
                    end
                end else if (prog_we) begin
                    mem_we = 1'b1;
                end
            end

            S_RUN: begin
                // The final address was already issued; no wrap to word 0.
                if (last_q) begin
                    state_d = S_DONE;
                end else if (fetch_en) begin
                    if (wp_cmd == HALT_CMD) begin
                        state_d = S_DONE;
                    end else begin
                        cmd_d  = wp_cmd;
                        data_d = wp_opd;
                        if (pc_q == LAST_ADDR) begin
                            last_d = 1'b1;
                        end else begin
                            pc_d = pc_q + AW'(1);
                        end
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign cmd_out  = cmd_q;
    assign data_out = data_q;
    assign pc       = pc_q;
    assign busy     = (state_q == S_RUN);
    assign done     = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_command_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_command_sequencer
// Brief    : Self-checking bench for command_sequencer using a program-level
//            reference model (expected issue sequence derived from memory).
// Revision : 1.0 - initial release
// ============================================================================
module tb_command_sequencer;

    localparam int         DEPTH = 16;
    localparam int         AW    = 4;
    localparam logic [3:0] NOP   = 4'hE;
    localparam logic [3:0] HALT  = 4'hF;

    logic          clock     = 1'b0;
    logic          CLR       = 1'b1;
    logic          prog_we   = 1'b0;
    logic [AW-1:0] prog_addr = '0;
    logic [11:0]   prog_data = '0;
    logic          start     = 1'b0;
`ifdef SINGLE_STEP_EN
    logic          step      = 1'b1;
`endif
    logic [3:0]    cmd_out;
    logic [7:0]    data_out;
    logic [AW-1:0] pc;
    logic          busy;
    logic          done;

    logic [11:0]   model_mem [DEPTH];
    int            tests = 0;
    int            fails = 0;

    command_sequencer #(
        .DEPTH    (DEPTH),
        .AW       (AW),
        .NOP_CMD  (NOP),
        .HALT_CMD (HALT)
    ) dut (
        .clock     (clock),
        .CLR       (CLR),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .start     (start),
`ifdef SINGLE_STEP_EN
        .step      (step),
`endif
        .cmd_out   (cmd_out),
        .data_out  (data_out),
        .pc        (pc),
        .busy      (busy),
        .done      (done)
    );

    always #5 clock = ~clock;

    task automatic write_word(input int a, input logic [11:0] w);
        @(negedge clock);
        prog_we   = 1'b1;
        prog_addr = AW'(a);
        prog_data = w;
        model_mem[a] = w;
        @(posedge clock);
        #1 prog_we = 1'b0;
    endtask

    // Expected behaviour: words 0..n-1 (up to first HALT, at most DEPTH) issued
    // back-to-back, then one NOP cycle with done, then idle.
    task automatic test_program_run(input string name, input bit noise, input bit we_with_start);
        int n;
        logic [17:0] obs, exp;
        logic [AW-1:0] pc_end;
        n = 0;
        while (n < DEPTH && model_mem[n][11:8] != HALT) n++;
        pc_end = (n == DEPTH) ? AW'(DEPTH - 1) : AW'(n);

        @(negedge clock);
        start = 1'b1;
        if (we_with_start) begin
            prog_we   = 1'b1;
            prog_addr = '0;
            prog_data = {HALT, 8'h00};
        end
        @(negedge clock);
        start   = 1'b0;
        prog_we = 1'b0;

        for (int i = 0; i < n; i++) begin
            obs = {cmd_out, data_out, busy, done, pc};
            exp = {model_mem[i][11:8], model_mem[i][7:0], 1'b1, 1'b0,
                   (i + 1 > DEPTH - 1) ? AW'(DEPTH - 1) : AW'(i + 1)};
            tests++;
            if (obs !== exp) begin
                fails++;
                $display("FAIL %s issue%0d: got {cmd,data,busy,done,pc}=%h expected %h", name, i, obs, exp);
            end
            if (noise) begin
                start     = 1'($urandom_range(0, 1));
                prog_we   = 1'b1;
                prog_addr = AW'($urandom_range(0, DEPTH - 1));
                prog_data = 12'($urandom);
            end
            @(negedge clock);
        end
        start   = 1'b0;
        prog_we = 1'b0;

        obs = {cmd_out, data_out, busy, done, pc};
        exp = {NOP, 8'h00, 1'b0, 1'b1, pc_end};
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s done: got {cmd,data,busy,done,pc}=%h expected %h", name, obs, exp);
        end
        @(negedge clock);
        obs = {cmd_out, data_out, busy, done, pc};
        exp = {NOP, 8'h00, 1'b0, 1'b0, pc_end};
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s idle: got {cmd,data,busy,done,pc}=%h expected %h", name, obs, exp);
        end
    endtask

    task automatic test_reset;
        logic [17:0] obs;
        @(negedge clock);
        obs = {cmd_out, data_out, busy, done, pc};
        tests++;
        if (obs !== {NOP, 8'h00, 1'b0, 1'b0, 4'h0}) begin
            fails++;
            $display("FAIL reset: got {cmd,data,busy,done,pc}=%h expected %h", obs, {NOP, 8'h00, 1'b0, 1'b0, 4'h0});
        end
        CLR = 1'b0;
    endtask

    task automatic test_basic;
        write_word(0, {4'h1, 8'h05});
        write_word(1, {4'h2, 8'h07});
        write_word(2, {HALT, 8'h00});
        test_program_run("basic", 1'b0, 1'b0);
    endtask

    task automatic test_full;
        for (int a = 0; a < DEPTH; a++)
            write_word(a, {4'($urandom_range(0, 14)), 8'($urandom)});
        test_program_run("full", 1'b0, 1'b0);
    endtask

    task automatic test_halt_first;
        write_word(0, {HALT, 8'h5A});
        test_program_run("halt_first", 1'b0, 1'b0);
    endtask

    task automatic test_random;
        int hp;
        for (int r = 0; r < 6; r++) begin
            hp = $urandom_range(0, DEPTH);
            for (int a = 0; a < DEPTH; a++)
                write_word(a, (a == hp) ? {HALT, 8'($urandom)}
                                        : {4'($urandom_range(0, 14)), 8'($urandom)});
            test_program_run("random_noise", 1'b1, 1'b0);
            test_program_run("random_replay", 1'b0, 1'b0);
        end
    endtask

    task automatic test_reset_mid_run;
        logic [17:0] obs, exp;
        for (int a = 0; a < DEPTH; a++)
            write_word(a, (a == 10) ? {HALT, 8'h00} : {4'($urandom_range(0, 14)), 8'($urandom)});
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (2) @(negedge clock);
        obs = {cmd_out, data_out, busy, done, pc};
        exp = {model_mem[2][11:8], model_mem[2][7:0], 1'b1, 1'b0, 4'h3};
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL midrun_word2: got %h expected %h", obs, exp);
        end
        #2 CLR = 1'b1;
        #1;
        obs = {cmd_out, data_out, busy, done, pc};
        exp = {NOP, 8'h00, 1'b0, 1'b0, 4'h0};
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL midrun_clr: got %h expected %h", obs, exp);
        end
        @(negedge clock);
        CLR = 1'b0;
        test_program_run("after_clr", 1'b0, 1'b0);
    endtask

    task automatic test_start_with_we;
        write_word(0, {4'h3, 8'h11});
        write_word(1, {4'h4, 8'h22});
        write_word(2, {HALT, 8'h00});
        test_program_run("start_we", 1'b0, 1'b1);
        test_program_run("start_we_replay", 1'b0, 1'b0);
    endtask

`ifdef SINGLE_STEP_EN
    task automatic test_single_step;
        int k, n;
        bit fin, s;
        logic [17:0] obs, exp;
        write_word(0, {4'h1, 8'h05});
        write_word(1, {4'h2, 8'h07});
        write_word(2, {4'h3, 8'h09});
        write_word(3, {HALT, 8'h00});
        n = 3;
        @(negedge clock);
        start = 1'b1;
        step  = 1'b0;
        @(negedge clock);
        start = 1'b0;
        obs = {cmd_out, data_out, busy, done, pc};
        exp = {4'h1, 8'h05, 1'b1, 1'b0, 4'h1};
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL step_first: got %h expected %h", obs, exp);
        end
        k   = 1;
        fin = 1'b0;
        for (int c = 1; c <= 20 && !fin; c++) begin
            s    = (c % 3 == 0);
            step = s;
            @(negedge clock);
            if (s && k < n) begin
                exp = {model_mem[k][11:8], model_mem[k][7:0], 1'b1, 1'b0, AW'(k + 1)};
                k++;
            end else if (s) begin
                exp = {NOP, 8'h00, 1'b0, 1'b1, AW'(n)};
                fin = 1'b1;
            end else begin
                exp = {NOP, 8'h00, 1'b1, 1'b0, AW'(k)};
            end
            obs = {cmd_out, data_out, busy, done, pc};
            tests++;
            if (obs !== exp) begin
                fails++;
                $display("FAIL step_cyc%0d: got %h expected %h", c, obs, exp);
            end
        end
        step = 1'b1;
        tests++;
        if (!fin) begin
            fails++;
            $display("FAIL step_finish: got no done, expected done within 20 cycles");
        end
        @(negedge clock);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_halt_first();
        test_reset_mid_run();
        test_start_with_we();
        test_random();
`ifdef SINGLE_STEP_EN
        test_single_step();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
